// File: rtl/somador_arbitro.sv
// Two-requester round-robin front end for a shared 16-bit add/subtract unit (somador).
// Define ARB_OVERFLOW_EN to add the registered signed-overflow output p_Overflow.

module somador (
  input  logic [15:0] p_A,
  input  logic [15:0] p_B,
  input  logic        p_Controle,
  output logic [15:0] p_S
);
  // Controle = 1 adds, 0 subtracts; both wrap modulo 2^16.
  assign p_S = p_Controle ? (p_A + p_B) : (p_A - p_B);
endmodule

module somador_arbitro #(
  parameter int WIDTH = 16
) (
  input  logic             p_Clock,
  input  logic             p_Reset_n,
  input  logic [1:0]       p_Req,
  input  logic [WIDTH-1:0] p_A0,
  input  logic [WIDTH-1:0] p_B0,
  input  logic [WIDTH-1:0] p_A1,
  input  logic [WIDTH-1:0] p_B1,
  input  logic [1:0]       p_Op,
  output logic [1:0]       p_Grant,
  output logic [1:0]       p_Done,
  output logic [WIDTH-1:0] p_Result,
`ifdef ARB_OVERFLOW_EN
  output logic             p_Overflow,
`endif
  output logic             p_Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_take;
  logic             w_winner;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_idx;
  logic             r_last;
  logic [1:0]       r_grant;
  logic [1:0]       r_done;
  logic [WIDTH-1:0] r_result;
  logic [15:0]      w_sum;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge p_Clock or negedge p_Reset_n) begin
    if (!p_Reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_winner     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|p_Req) begin
          w_take       = 1'b1;
          // On contention the requester not served last wins.
          w_winner     = (&p_Req) ? ~r_last : p_Req[1];
          w_state_next = S_EXEC;
        end
      end
      S_EXEC:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  somador u_somador (
    .p_A        (r_a),
    .p_B        (r_b),
    .p_Controle (r_op),
    .p_S        (w_sum)
  );

`ifdef ARB_OVERFLOW_EN
  logic r_overflow;
  logic w_overflow;

  always_comb begin
    if (r_op) w_overflow = (r_a[15] == r_b[15]) && (w_sum[15] != r_a[15]);
    else      w_overflow = (r_a[15] != r_b[15]) && (w_sum[15] != r_a[15]);
  end

  always_ff @(posedge p_Clock or negedge p_Reset_n) begin
    if (!p_Reset_n)              r_overflow <= 1'b0;
    else if (r_state == S_EXEC)  r_overflow <= w_overflow;
  end

  assign p_Overflow = r_overflow;
`endif

  always_ff @(posedge p_Clock or negedge p_Reset_n) begin
    if (!p_Reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_idx    <= 1'b0;
      r_last   <= 1'b1;
      r_grant  <= 2'b00;
      r_done   <= 2'b00;
      r_result <= '0;
    end else begin
      r_grant <= 2'b00;
      r_done  <= 2'b00;
      if (w_take) begin
        r_a     <= w_winner ? p_A1 : p_A0;
        r_b     <= w_winner ? p_B1 : p_B0;
        r_op    <= p_Op[w_winner];
        r_idx   <= w_winner;
        r_last  <= w_winner;
        r_grant <= w_winner ? 2'b10 : 2'b01;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_sum;
        r_done   <= r_idx ? 2'b10 : 2'b01;
      end
    end
  end

  assign p_Grant  = r_grant;
  assign p_Done   = r_done;
  assign p_Result = r_result;
  assign p_Busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_somador_arbitro.sv
// Scoreboard bench for somador_arbitro: expected results are queued at grant and checked at done.
// Overflow checks are compiled in only when ARB_OVERFLOW_EN is defined.

module tb_somador_arbitro;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  op = 2'b00;
  logic [1:0]  grant, done;
  logic [15:0] result;
  logic        busy;
`ifdef ARB_OVERFLOW_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [1:0]  onehot;
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  somador_arbitro #(.WIDTH(16)) dut (
    .p_Clock    (clk),
    .p_Reset_n  (rst_n),
    .p_Req      (req),
    .p_A0       (a0),
    .p_B0       (b0),
    .p_A1       (a1),
    .p_B1       (b1),
    .p_Op       (op),
    .p_Grant    (grant),
    .p_Done     (done),
    .p_Result   (result),
`ifdef ARB_OVERFLOW_EN
    .p_Overflow (ovf),
`endif
    .p_Busy     (busy)
  );

  function automatic exp_t model(input int idx, input logic [15:0] a, input logic [15:0] b,
                                 input logic add);
    exp_t e;
    e.onehot = (idx == 1) ? 2'b10 : 2'b01;
    e.res    = add ? 16'(a + b) : 16'(a - b);
    if (add) e.ovf = (a[15] == b[15]) && (e.res[15] != a[15]);
    else     e.ovf = (a[15] != b[15]) && (e.res[15] != a[15]);
    return e;
  endfunction

  task automatic check_done(input string name);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $display("FAIL %s: done=%b seen with empty scoreboard", name, done);
      return;
    end
    e = sb.pop_front();
    if (done !== e.onehot) begin
      n_mis++;
      $display("FAIL %s done: got %b want %b", name, done, e.onehot);
    end
    n_cmp++;
    if (result !== e.res) begin
      n_mis++;
      $display("FAIL %s result: got %h want %h", name, result, e.res);
    end
`ifdef ARB_OVERFLOW_EN
    n_cmp++;
    if (ovf !== e.ovf) begin
      n_mis++;
      $display("FAIL %s overflow: got %b want %b", name, ovf, e.ovf);
    end
`endif
  endtask

  // Waits (bounded) for a nonzero grant at a negedge; returns 0 on timeout.
  task automatic wait_grant(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (grant !== 2'b00) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s: grant timeout", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request from requester idx; optionally disturbs its A operand right after grant.
  task automatic do_op(input string name, input int idx, input logic [15:0] a,
                       input logic [15:0] b, input logic add, input bit disturb);
    bit ok;
    logic [1:0] want_g;
    logic [15:0] held;
    want_g = (idx == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    if (idx == 1) begin a1 = a; b1 = b; op[1] = add; end
    else          begin a0 = a; b0 = b; op[0] = add; end
    req[idx] = 1'b1;
    wait_grant(name, ok);
    if (!ok) begin req = 2'b00; return; end
    n_cmp++;
    if (grant !== want_g) begin
      n_mis++;
      $display("FAIL %s grant: got %b want %b", name, grant, want_g);
    end
    sb.push_back(model(idx, a, b, add));
    req[idx] = 1'b0;
    if (disturb) begin
      if (idx == 1) begin a1 = 16'h1234; op[1] = ~add; end
      else          begin a0 = 16'h1234; op[0] = ~add; end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_mis++;
      $display("FAIL %s busy: got %b want 1", name, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (grant !== 2'b00) begin
      n_mis++;
      $display("FAIL %s grant pulse: got %b want 00", name, grant);
    end
    check_done(name);
    held = result;
    @(negedge clk);
    n_cmp++;
    if (done !== 2'b00 || busy !== 1'b0 || result !== held) begin
      n_mis++;
      $display("FAIL %s idle: done=%b busy=%b result=%h want 00/0/%h", name, done, busy, result, held);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (grant !== 2'b00 || done !== 2'b00 || result !== 16'h0000 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset: grant=%b done=%b result=%h busy=%b want 00/00/0000/0", grant, done, result, busy);
    end
`ifdef ARB_OVERFLOW_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_mis++;
      $display("FAIL reset overflow: got %b want 0", ovf);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    do_op("add", 0, 16'h0003, 16'h0004, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    do_op("sub_wrap", 1, 16'h0000, 16'h0001, 1'b0, 1'b0);
    do_op("add_wrap", 0, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    do_op("sub_plain", 1, 16'h1000, 16'h0234, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    do_op("ovf_add", 0, 16'h7FFF, 16'h0001, 1'b1, 1'b0);
    do_op("ovf_sub", 1, 16'h8000, 16'h0001, 1'b0, 1'b0);
    do_op("noovf_add", 0, 16'hFFFE, 16'h0001, 1'b1, 1'b0);
  endtask

  task automatic test_operand_change();
    do_op("late_change", 0, 16'h0010, 16'h0005, 1'b1, 1'b1);
  endtask

  task automatic test_contention();
    bit ok;
    int gap;
    logic [1:0] want_g;
    do_reset();
    @(negedge clk);
    a0 = 16'd100; b0 = 16'd1;  op[0] = 1'b1;
    a1 = 16'd50;  b1 = 16'd20; op[1] = 1'b0;
    req = 2'b11;
    gap = 0;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        @(negedge clk);
        gap++;
        if (grant !== 2'b00) ok = 1'b1;
      end
      if (!ok) begin
        n_cmp++;
        n_mis++;
        $display("FAIL contention %0d: grant timeout", k);
        break;
      end
      want_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      n_cmp++;
      if (grant !== want_g) begin
        n_mis++;
        $display("FAIL contention %0d grant: got %b want %b", k, grant, want_g);
      end
      if (k > 0) begin
        n_cmp++;
        if (gap != 3) begin
          n_mis++;
          $display("FAIL contention %0d spacing: got %0d cycles want 3", k, gap);
        end
      end
      if (k % 2 == 1) sb.push_back(model(1, a1, b1, op[1]));
      else            sb.push_back(model(0, a0, b0, op[0]));
      gap = 0;
      @(negedge clk);
      gap++;
      check_done("contention");
    end
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    bit saw_done;
    @(negedge clk);
    a0 = 16'h0101; b0 = 16'h0202; op[0] = 1'b1;
    req = 2'b01;
    wait_grant("mid_reset", ok);
    req = 2'b00;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (grant !== 2'b00 || done !== 2'b00 || result !== 16'h0000 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL mid_reset outputs: grant=%b done=%b result=%h busy=%b want 00/00/0000/0", grant, done, result, busy);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 2'b00) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 2'b00) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_mis++;
      $display("FAIL mid_reset: done pulse after reset, got 1 want 0");
    end
    a0 = 16'h0008; b0 = 16'h0003; op[0] = 1'b0;
    a1 = 16'h0009; b1 = 16'h0001; op[1] = 1'b1;
    req = 2'b11;
    wait_grant("post_reset", ok);
    if (ok) begin
      n_cmp++;
      if (grant !== 2'b01) begin
        n_mis++;
        $display("FAIL post_reset grant: got %b want 01", grant);
      end
      sb.push_back(model(0, a0, b0, op[0]));
      req = 2'b00;
      @(negedge clk);
      check_done("post_reset");
    end
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_wrap();
    test_overflow();
    test_operand_change();
    test_contention();
    test_reset_mid_op();
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/somador_arbitro.md
# somador_arbitro

Shares one 16-bit add/subtract unit (`somador`) between two requesters. The block captures the winning requester's operands and operation, drives them into an internally instantiated `somador` and registers the result. It then signals completion back to that requester. Round-robin arbitration guarantees neither requester starves. It sits between two datapath clients and the single arithmetic unit.

## Interface
- `WIDTH`, 16: operand/result width; passed to operand registers; `somador` instance fixed at 16, so only 16 is supported.
- `p_Clock`  in  1  system clock, rising edge.
- `p_Reset_n`  in  1  asynchronous active-low reset.
- `p_Req`  in  2  request per requester (bit i = requester i); level, held until granted.
- `p_A0`, `p_B0`  in  16  requester 0 operands.
- `p_A1`, `p_B1`  in  16  requester 1 operands.
- `p_Op`  in  2  bit i = requester i operation: 1 = add (A+B), 0 = subtract (A−B).
- `p_Grant`  out  2  one-hot, one-cycle pulse: operands of requester i captured.
- `p_Done`  out  2  one-hot, one-cycle pulse: result for requester i valid.
- `p_Result`  out  16  registered result of last completed operation.
- `p_Busy`  out  1  high whenever state ≠ IDLE.
- `p_Overflow`  out  1  only with `ARB_OVERFLOW_EN` (see Configuration).

## Operation
- FSM states: IDLE, EXEC, DONE. Reset → IDLE.
- IDLE, `p_Req` = 00: stay.
- IDLE, exactly one `p_Req` bit set: that requester wins.
- IDLE, both set: winner = requester not served last (`last` pointer). The `last` reset value is 1, so requester 0 wins first contention.
- On IDLE edge with winner:
  - latch winner's A, B, op into operand registers;
  - record winner index and update `last` = winner;
  - set `p_Grant[winner]`;
  - go to EXEC.
- EXEC:
  - `somador` sees operand registers, with p_Controle = latched op;
  - at edge, `p_Result` ← `somador` output;
  - set `p_Done[winner]`;
  - go to DONE.
- DONE: one cycle; go to IDLE at next edge. Requests are not sampled in EXEC or DONE.
- Arithmetic: modulo 2^16, wrap-around. 0x0000 − 0x0001 = 0xFFFF; 0xFFFF + 0x0001 = 0x0000.
- Requester protocol:
  - deassert own `p_Req` in the cycle `p_Grant` is seen;
  - a request still high when FSM returns to IDLE is a new request;
  - operand/op changes after grant have no effect on the in-flight operation.
- `p_Result` holds its value until the next EXEC edge.
- Reset mid-operation: asynchronous.
  - Immediately: state IDLE, in-flight operation discarded, no `p_Done` issued.
  - Outputs return to reset values.

## Timing
- Reset values: `p_Grant` = 00, `p_Done` = 00, `p_Result` = 0x0000, `p_Busy` = 0, `p_Overflow` = 0, `last` = 1, operand registers = 0.
- Request sampled at edge k (IDLE). `p_Grant` high in cycle k..k+1. `p_Done` and new `p_Result` valid in cycle k+1..k+2. IDLE again after edge k+2.
- Latency request-to-done: 2 cycles.
- Throughput: one operation per 3 cycles. Back-to-back alternating grants when both requesters keep requesting.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `ARB_OVERFLOW_EN` defined: `p_Overflow` port exists.
  - Registered at the EXEC edge with `p_Result`.
  - Signed two's-complement overflow of the executed op.
    - add: operand signs equal and result sign differs;
    - sub: operand signs differ and result sign ≠ sign of A.
  - Holds value with `p_Result`.
- Not defined: port and logic absent; all other behaviour identical.

## Test plan
- Single add: reset; `p_Req`=01, A0=0x0003, B0=0x0004, op0=1 -> `p_Grant`=01 next cycle, `p_Done`=01 one cycle later, `p_Result`=0x0007.
- Subtract wrap: requester 1, A1=0x0000, B1=0x0001, op1=0 -> `p_Done`=10, `p_Result`=0xFFFF. With macro: `p_Overflow`=0.
- Contention fairness: `p_Req`=11 held continuously from reset -> grants 01,10,01,10, each 3 cycles apart; `p_Result` alternates per requester operands.
- Operand change after grant: change A0 to 0x1234 in the cycle after `p_Grant`=01 -> result uses originally latched A0.
- Overflow (macro defined): A=0x7FFF, B=0x0001, add -> `p_Result`=0x8000, `p_Overflow`=1. Then A=0x8000, B=0x0001, sub -> `p_Result`=0x7FFF, `p_Overflow`=1.
- Reset mid-operation: assert `p_Reset_n`=0 during EXEC -> outputs immediately at reset values, no `p_Done` pulse. After release, `p_Req`=11 -> requester 0 granted first.
